ccff_chain_loader: RTL and testbench



---
 rtl/ccff_loader_pkg.sv | 18 +
 rtl/ccff_word_serdes.sv | 46 ++++
 rtl/ccff_chain_loader.sv | 82 ++++++++
 tb/tb_ccff_chain_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared FSM encoding and sizing helpers for the config-chain loader
package ccff_loader_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, RBACK, DONE} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/ccff_word_serdes.sv
// ccff_word_serdes: serializes one word onto the chain head and deserializes the tail into a readback word
module ccff_word_serdes #(
    parameter int WORD_W = 8,
    parameter int NB_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    input  logic [NB_W-1:0]   nbits,
    input  logic              tail,
    output logic              head,
    output logic [WORD_W-1:0] rd_data,
    output logic              last_bit
);

    logic [WORD_W-1:0] tx_sr;
    logic [WORD_W-1:0] rx_sr;
    logic [NB_W-1:0]   nb;
    logic [NB_W-1:0]   cnt;

    // Load a fresh word, then move it out MSB-first while the old chain bits arrive at the LSB
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr <= '0;
            rx_sr <= '0;
            nb    <= '0;
            cnt   <= '0;
        end else if (load) begin
            tx_sr <= word;
            rx_sr <= '0;
            nb    <= nbits;
            cnt   <= '0;
        end else if (shift) begin
            tx_sr <= tx_sr << 1;
            rx_sr <= {rx_sr[WORD_W-2:0], tail};
            cnt   <= cnt + NB_W'(1);
        end
    end

    assign head     = tx_sr[WORD_W-1];
    assign last_bit = cnt == nb - NB_W'(1);
    assign rd_data  = rx_sr << (NB_W'(WORD_W) - nb);

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: writes a bitstream into the config flip-flop chain while reading back its old contents
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 256,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = clog2(CHAIN_LEN + 1);
    localparam int NB_W  = clog2(WORD_W + 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [31:0]       rem;
    logic [NB_W-1:0]   nbits;
    logic              head;
    logic              last_bit;
    logic [WORD_W-1:0] rx_word;

    assign rem   = 32'(CHAIN_LEN) - 32'(bit_cnt);
    assign nbits = NB_W'((rem < 32'(WORD_W)) ? rem : 32'(WORD_W));

    // Pass sequencing: fetch a word, shift its bits, hand back readback, repeat until the chain is full
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    bit_cnt <= '0;
                    state   <= FETCH;
                end
                FETCH: if (word_valid) state <= SHIFT;
                SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) state <= RBACK;
                end
                RBACK: if (rd_ready) state <= (bit_cnt == CNT_W'(CHAIN_LEN)) ? DONE : FETCH;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    ccff_word_serdes #(.WORD_W(WORD_W), .NB_W(NB_W)) u_serdes (
        .clk      (prog_clk),
        .rst      (prog_reset),
        .load     (state == FETCH && word_valid),
        .shift    (state == SHIFT),
        .word     (word_data),
        .nbits    (nbits),
        .tail     (ccff_tail),
        .head     (head),
        .rd_data  (rx_word),
        .last_bit (last_bit)
    );

    assign word_ready  = state == FETCH;
    assign rd_valid    = state == RBACK;
    assign rd_data     = rx_word;
    assign ccff_clk_en = state == SHIFT;
    assign ccff_head   = head && state == SHIFT;
    assign busy        = state != IDLE;
    assign done        = state == DONE;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed checks of the chain loader against behavioural 20- and 16-flop chains
module tb_ccff_chain_loader;
    import ccff_loader_pkg::*;

    logic       clk = 0;
    logic       rst = 1;
    logic       start_a = 0, start_b = 0;
    logic [7:0] wdata = 0;
    logic       wvalid = 0, rready = 0;

    logic       wr_a, rv_a, head_a, en_a, busy_a, done_a;
    logic       wr_b, rv_b, head_b, en_b, busy_b, done_b;
    logic [7:0] rd_a, rd_b;
    logic [19:0] chain_a = '0;
    logic [15:0] chain_b = '0;

    int n_chk = 0, n_err = 0;
    int en_cnt, done_cyc, ri;
    logic [63:0] en_map;
    logic [7:0]  rb [0:3];
    bit          unstable;

    always #5 clk = ~clk;

    always @(posedge clk) if (en_a) chain_a <= {chain_a[18:0], head_a};
    always @(posedge clk) if (en_b) chain_b <= {chain_b[14:0], head_b};

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_a (
        .prog_clk(clk), .prog_reset(rst), .start(start_a), .word_data(wdata),
        .word_valid(wvalid), .word_ready(wr_a), .rd_data(rd_a), .rd_valid(rv_a),
        .rd_ready(rready), .ccff_head(head_a), .ccff_clk_en(en_a),
        .ccff_tail(chain_a[19]), .busy(busy_a), .done(done_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_b (
        .prog_clk(clk), .prog_reset(rst), .start(start_b), .word_data(wdata),
        .word_valid(wvalid), .word_ready(wr_b), .rd_data(rd_b), .rd_valid(rv_b),
        .rd_ready(rready), .ccff_head(head_b), .ccff_clk_en(en_b),
        .ccff_tail(chain_b[15]), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One load pass on DUT a (b=0) or b (b=1); results land in en_cnt, en_map, done_cyc, rb, unstable
    task automatic run_pass(input bit b, input logic [7:0] w0, w1, w2,
                            input int fstall, rstall, start_cyc, abort_cyc);
        int wi, fs, rs;
        bit fin, acc, rv_prev;
        logic [7:0] held;
        logic en_s, wr_s, rv_s, dn_s;
        logic [7:0] rd_s;
        wi = 0; fs = fstall; rs = rstall; fin = 0; acc = 0; rv_prev = 0; held = 0;
        en_cnt = 0; en_map = 0; done_cyc = -1; ri = 0; unstable = 0;
        wdata = w0; wvalid = 1; rready = 1;
        @(negedge clk);
        start_a = !b; start_b = b;
        @(posedge clk); #1;
        start_a = 0; start_b = 0;
        for (int c = 1; c < 80 && !fin; c++) begin
            if (acc) wi++;
            en_s = b ? en_b : en_a;
            wr_s = b ? wr_b : wr_a;
            rv_s = b ? rv_b : rv_a;
            dn_s = b ? done_b : done_a;
            rd_s = b ? rd_b : rd_a;
            if (en_s) begin en_cnt++; en_map[c] = 1'b1; end
            if (dn_s) begin done_cyc = c; fin = 1; end
            if (rv_s) begin
                if (!rv_prev) held = rd_s;
                else if (rd_s !== held) unstable = 1;
            end
            rv_prev = rv_s;
            wvalid = !(wr_s && fs > 0);
            if (wr_s && fs > 0) fs--;
            rready = !(rv_s && rs > 0);
            if (rv_s && rs > 0) rs--;
            if (rv_s && rready && ri < 4) begin rb[ri] = rd_s; ri++; end
            acc = wr_s && wvalid;
            wdata = (wi == 0) ? w0 : (wi == 1) ? w1 : w2;
            start_a = !b && c == start_cyc;
            start_b = b && c == start_cyc;
            if (c == abort_cyc) begin
                rst = 1;
                @(posedge clk); #1;
                rst = 0;
                chk("abort_en", en_a, 0);
                chk("abort_busy", busy_a, 0);
                fin = 1;
            end else if (!fin) begin
                @(posedge clk); #1;
            end
        end
        start_a = 0; start_b = 0;
        chk("pass_ended", fin, 1);
        if (abort_cyc == 0) begin
            @(posedge clk); #1;
            chk("done_one_cycle", b ? done_b : done_a, 0);
            chk("idle_after_done", b ? busy_b : busy_a, 0);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_word_ready", wr_a, 0);
        chk("rst_rd_valid", rv_a, 0);
        chk("rst_clk_en", en_a, 0);
        chk("rst_head", head_a, 0);
        chk("rst_rd_data", rd_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 0; wvalid = 1; rready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy_a, 0);
        chk("idle_word_ready", wr_a, 0);
        chk("idle_clk_en", en_a, 0);

        // Fresh load into a zeroed chain
        run_pass(0, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 0);
        chk("p1_en_cnt", en_cnt, 20);
        chk("p1_en_map", en_map, 64'h3CF_F3FC);
        chk("p1_done_cyc", done_cyc, 27);
        chk("p1_nwords", ri, ceil_div(20, 8));
        chk("p1_rb0", rb[0], 8'h00);
        chk("p1_rb1", rb[1], 8'h00);
        chk("p1_rb2", rb[2], 8'h00);
        chk("p1_chain", chain_a, 20'hA53CF);

        // Second pass reads back the first bitstream
        run_pass(0, 8'h12, 8'h34, 8'h50, 0, 0, 0, 0);
        chk("p2_en_cnt", en_cnt, 20);
        chk("p2_done_cyc", done_cyc, 27);
        chk("p2_rb0", rb[0], 8'hA5);
        chk("p2_rb1", rb[1], 8'h3C);
        chk("p2_rb2", rb[2], 8'hF0);
        chk("p2_chain", chain_a, 20'h12345);

        // Host stalls in FETCH and RBACK
        run_pass(0, 8'hC3, 8'h5A, 8'h9F, 5, 3, 0, 0);
        chk("p3_en_cnt", en_cnt, 20);
        chk("p3_en_map", en_map, 64'h3_CFF0_7F80);
        chk("p3_done_cyc", done_cyc, 35);
        chk("p3_rd_stable", unstable, 0);
        chk("p3_rb0", rb[0], 8'h12);
        chk("p3_rb1", rb[1], 8'h34);
        chk("p3_rb2", rb[2], 8'h50);
        chk("p3_chain", chain_a, 20'hC35A9);

        // start pulsed mid-SHIFT is ignored
        run_pass(0, 8'h11, 8'h22, 8'h33, 0, 0, 5, 0);
        chk("p4_en_cnt", en_cnt, 20);
        chk("p4_done_cyc", done_cyc, 27);
        chk("p4_rb0", rb[0], 8'hC3);
        chk("p4_rb2", rb[2], 8'h90);
        chk("p4_chain", chain_a, 20'h11223);

        // Reset during SHIFT of word 2: 8 + 3 bits entered the chain
        run_pass(0, 8'h44, 8'h55, 8'h66, 0, 0, 0, 14);
        chk("p5_en_cnt", en_cnt, 11);
        chk("p5_chain", chain_a, {9'h023, 8'h44, 3'b010});

        // Fresh full pass after the abort
        run_pass(0, 8'h77, 8'h88, 8'h99, 0, 0, 0, 0);
        chk("p6_en_cnt", en_cnt, 20);
        chk("p6_done_cyc", done_cyc, 27);
        chk("p6_rb0", rb[0], 8'h11);
        chk("p6_rb1", rb[1], 8'hA2);
        chk("p6_rb2", rb[2], 8'h20);
        chk("p6_chain", chain_a, 20'h77889);

        // Chain length a multiple of the word width
        run_pass(1, 8'hDE, 8'hAD, 8'h00, 0, 0, 0, 0);
        chk("b_en_cnt", en_cnt, 16);
        chk("b_en_map", en_map, 64'hF_F3FC);
        chk("b_done_cyc", done_cyc, 21);
        chk("b_nwords", ri, ceil_div(16, 8));
        chk("b_rb0", rb[0], 8'h00);
        chk("b_chain", chain_b, 16'hDEAD);
        chk("b_a_untouched", chain_a, 20'h77889);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
